// File: rtl/regfile_access_seq.sv
// Initiator-side sequencer for the single-port register file: serialises READ2/WRITE/PUSH/POP
// requests into register-file strobes and returns captured operands over a valid/ready channel.
module regfile_access_seq #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ID_W   = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ID_W-1:0]   req_src_a,
   input  logic [ID_W-1:0]   req_src_b,
   input  logic [ID_W-1:0]   req_dst,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_op_a,
   output logic [DATA_W-1:0] rsp_op_b,
   output logic              rf_rd,
   output logic              rf_wn,
   output logic              rf_stack_en,
   output logic              rf_push_en,
   output logic              rf_pop_en,
   output logic [ID_W-1:0]   rf_reg_id,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic [DATA_W-1:0] rf_read_data
);

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      CAP_B,
      WR,
      STK,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      OP_READ2 = 2'b00,
      OP_WRITE = 2'b01,
      OP_PUSH  = 2'b10,
      OP_POP   = 2'b11
   } op_t;

   localparam logic [ID_W-1:0] STACK_ID = ID_W'(2);

   state_t              state, state_nx;
   op_t                 op_q;
   logic [ID_W-1:0]     src_a_q, src_b_q, dst_q;
   logic [DATA_W-1:0]   wdata_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         op_q     <= OP_READ2;
         src_a_q  <= '0;
         src_b_q  <= '0;
         dst_q    <= '0;
         wdata_q  <= '0;
         rsp_op_a <= '0;
         rsp_op_b <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && req_valid) begin
            op_q    <= op_t'(req_op);
            src_a_q <= req_src_a;
            src_b_q <= req_src_b;
            dst_q   <= req_dst;
            wdata_q <= req_wdata;
         end
         // read_data lags rf_rd by one cycle: RD_B sees src_a's data, CAP_B sees src_b's
         if (state == RD_B)
            rsp_op_a <= rf_read_data;
         if (state == CAP_B)
            rsp_op_b <= rf_read_data;
      end
   end

   always_comb begin
      state_nx      = state;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      rf_rd         = 1'b0;
      rf_wn         = 1'b0;
      rf_stack_en   = 1'b0;
      rf_push_en    = 1'b0;
      rf_pop_en     = 1'b0;
      rf_reg_id     = '0;
      rf_write_data = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               case (op_t'(req_op))
                  OP_READ2: state_nx = RD_A;
                  OP_WRITE: state_nx = WR;
                  default:  state_nx = STK;
               endcase
            end
         end
         RD_A: begin
            rf_rd     = 1'b1;
            rf_reg_id = src_a_q;
            state_nx  = RD_B;
         end
         RD_B: begin
            rf_rd     = 1'b1;
            rf_reg_id = src_b_q;
            state_nx  = CAP_B;
         end
         CAP_B: begin
            state_nx = RESP;
         end
         WR: begin
            rf_wn         = 1'b1;
            rf_reg_id     = dst_q;
            rf_write_data = wdata_q;
            state_nx      = RESP;
         end
         STK: begin
            rf_stack_en = 1'b1;
            rf_push_en  = (op_q == OP_PUSH);
            rf_pop_en   = (op_q == OP_POP);
            rf_reg_id   = STACK_ID;
            state_nx    = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_regfile_access_seq.sv
// Directed and random checks of regfile_access_seq against a behavioural register file
// (push increments r2, pop decrements it) and a reference register array.
module tb_regfile_access_seq;

   localparam logic [1:0] RD2 = 2'b00;
   localparam logic [1:0] WRT = 2'b01;
   localparam logic [1:0] PSH = 2'b10;
   localparam logic [1:0] POP = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [3:0]  req_src_a = '0, req_src_b = '0, req_dst = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_op_a, rsp_op_b;
   logic        rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en;
   logic [3:0]  rf_reg_id;
   logic [15:0] rf_write_data;
   logic [15:0] rf_read_data;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   regfile_access_seq #(.DATA_W(16), .ID_W(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op_a(rsp_op_a), .rsp_op_b(rsp_op_b),
      .rf_rd(rf_rd), .rf_wn(rf_wn), .rf_stack_en(rf_stack_en), .rf_push_en(rf_push_en),
      .rf_pop_en(rf_pop_en), .rf_reg_id(rf_reg_id), .rf_write_data(rf_write_data),
      .rf_read_data(rf_read_data)
   );

   function automatic logic [15:0] init_val(input int i);
      case (i)
         0:       return 16'h0001;
         2:       return 16'hFFFF;
         7:       return 16'h1234;
         default: return 16'hA000 + 16'(i);
      endcase
   endfunction

   // behavioural register file: registered read data, stack pointer in r2
   logic [15:0] rf_mem [16];
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) rf_mem[i] <= init_val(i);
         rf_read_data <= '0;
      end else begin
         if (rf_rd) rf_read_data <= rf_mem[rf_reg_id];
         if (rf_wn) rf_mem[rf_reg_id] <= rf_write_data;
         if (rf_stack_en && rf_push_en) rf_mem[2] <= rf_mem[2] + 16'd1;
         if (rf_stack_en && rf_pop_en)  rf_mem[2] <= rf_mem[2] - 16'd1;
      end
   end

   logic [15:0] ref_rf [16];
   logic [15:0] last_a, last_b;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [24:0] strobes();
      return {rf_rd, rf_wn, rf_stack_en, rf_push_en, rf_pop_en, rf_reg_id, rf_write_data};
   endfunction

   function automatic logic [24:0] exp_strobes(input logic [1:0] op, input int c,
         input logic [3:0] a, input logic [3:0] b, input logic [3:0] dst, input logic [15:0] wd);
      logic [24:0] e = '0;
      case (op)
         RD2: if (c == 1) e = {5'b10000, a, 16'h0};
              else if (c == 2) e = {5'b10000, b, 16'h0};
         WRT: if (c == 1) e = {5'b01000, dst, wd};
         PSH: if (c == 1) e = {5'b00110, 4'd2, 16'h0};
         POP: if (c == 1) e = {5'b00101, 4'd2, 16'h0};
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic ref_reset();
      for (int i = 0; i < 16; i++) ref_rf[i] = init_val(i);
      last_a = '0;
      last_b = '0;
   endtask

   task automatic ref_apply(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
         input logic [3:0] dst, input logic [15:0] wd);
      case (op)
         RD2: begin last_a = ref_rf[a]; last_b = ref_rf[b]; end
         WRT: ref_rf[dst] = wd;
         PSH: ref_rf[2] = ref_rf[2] + 16'd1;
         default: ref_rf[2] = ref_rf[2] - 16'd1;
      endcase
   endtask

   // issue one request from IDLE (called at a negedge), track strobes, hold off bp cycles, retire
   task automatic do_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
         input logic [3:0] dst, input logic [15:0] wd, input int bp,
         input logic [15:0] ea, input logic [15:0] eb);
      int lat;
      int c;
      logic [15:0] hold_a, hold_b;
      lat = (op == RD2) ? 4 : 2;
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_op = op; req_src_a = a; req_src_b = b; req_dst = dst; req_wdata = wd;
      rsp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_op = 2'($urandom); req_src_a = 4'($urandom); req_src_b = 4'($urandom);
      req_dst = 4'($urandom); req_wdata = 16'($urandom);
      c = 1;
      while (!rsp_valid && c <= 8) begin
         chk($sformatf("strobes_op%0d_c%0d", op, c), strobes(), exp_strobes(op, c, a, b, dst, wd));
         chk("req_ready_busy", req_ready, 0);
         @(negedge clk);
         c++;
      end
      chk($sformatf("latency_op%0d", op), c, lat);
      chk("resp_strobes_idle", strobes(), 0);
      chk("rsp_op_a", rsp_op_a, ea);
      chk("rsp_op_b", rsp_op_b, eb);
      hold_a = rsp_op_a;
      hold_b = rsp_op_b;
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_req_ready", req_ready, 0);
         chk("bp_ops_stable", {rsp_op_a, rsp_op_b}, {hold_a, hold_b});
         chk("bp_strobes", strobes(), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("after_rsp_ready", {req_ready, rsp_valid}, 2'b10);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [3:0]  a, b, dst;
      logic [15:0] wd;
      int          bp;
      logic [15:0] ea, eb;
   } vec_t;

   vec_t vecs [13];

   initial begin
      vecs[0]  = '{WRT, 4'd0, 4'd0, 4'd5,  16'hBEEF, 0, 16'h0000, 16'h0000};
      vecs[1]  = '{RD2, 4'd5, 4'd0, 4'd0,  16'h0000, 0, 16'hBEEF, 16'h0001};
      vecs[2]  = '{PSH, 4'd0, 4'd0, 4'd0,  16'h0000, 0, 16'hBEEF, 16'h0001};
      vecs[3]  = '{RD2, 4'd2, 4'd2, 4'd0,  16'h0000, 1, 16'h0000, 16'h0000};
      vecs[4]  = '{POP, 4'd0, 4'd0, 4'd0,  16'h0000, 0, 16'h0000, 16'h0000};
      vecs[5]  = '{RD2, 4'd2, 4'd7, 4'd0,  16'h0000, 0, 16'hFFFF, 16'h1234};
      vecs[6]  = '{RD2, 4'd7, 4'd7, 4'd0,  16'h0000, 6, 16'h1234, 16'h1234};
      vecs[7]  = '{WRT, 4'd0, 4'd0, 4'd2,  16'h0042, 2, 16'h1234, 16'h1234};
      vecs[8]  = '{RD2, 4'd2, 4'd3, 4'd0,  16'h0000, 0, 16'h0042, 16'hA003};
      vecs[9]  = '{WRT, 4'd0, 4'd0, 4'd15, 16'hFFFF, 0, 16'h0042, 16'hA003};
      vecs[10] = '{RD2, 4'd15, 4'd0, 4'd0, 16'h0000, 0, 16'hFFFF, 16'h0001};
      vecs[11] = '{PSH, 4'd0, 4'd0, 4'd0,  16'h0000, 0, 16'hFFFF, 16'h0001};
      vecs[12] = '{RD2, 4'd2, 4'd5, 4'd0,  16'h0000, 0, 16'h0043, 16'hBEEF};

      // power-on reset
      ref_reset();
      repeat (3) @(negedge clk);
      chk("reset_state", {req_ready, rsp_valid, strobes(), rsp_op_a, rsp_op_b},
          {2'b10, 25'h0, 32'h0});
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].wd, vecs[i].bp,
               vecs[i].ea, vecs[i].eb);
         ref_apply(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].wd);
      end

      // reset while in RD_B aborts the read; no response may follow
      req_valid = 1'b1; req_op = RD2; req_src_a = 4'd1; req_src_b = 4'd3;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_rd_a", strobes(), {5'b10000, 4'd1, 16'h0});
      @(negedge clk);
      chk("abort_rd_b", strobes(), {5'b10000, 4'd3, 16'h0});
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_in_reset", {req_ready, rsp_valid, strobes(), rsp_op_a, rsp_op_b},
             {2'b10, 25'h0, 32'h0});
      end
      reset = 1'b1;
      rsp_ready = 1'b1;
      ref_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_rsp", {req_ready, rsp_valid, strobes()}, {2'b10, 25'h0});
      end
      rsp_ready = 1'b0;

      // random sweep with reference-model expectations
      for (int n = 0; n < 1000; n++) begin
         logic [1:0]  op;
         logic [3:0]  a, b, dst;
         logic [15:0] wd, ea, eb;
         op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
         dst = 4'($urandom); wd = 16'($urandom);
         ea = (op == RD2) ? ref_rf[a] : last_a;
         eb = (op == RD2) ? ref_rf[b] : last_b;
         do_op(op, a, b, dst, wd, $urandom_range(0, 2), ea, eb);
         ref_apply(op, a, b, dst, wd);
      end
      for (int i = 0; i < 16; i++)
         chk($sformatf("final_r%0d", i), rf_mem[i], ref_rf[i]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_access_seq.md
# regfile_access_seq

Initiator-side sequencer for the single-port `Register` file. It accepts one operation per handshake from the decode stage: read two operands, write one register, or push/pop the stack pointer (register 2). It serialises each operation into `rd`/`wn`/`stack_en`/`push_en`/`pop_en` strobes toward the register file. It captures the registered `read_data` and returns results to the execute stage over a valid/ready response channel.

## Interface
- `DATA_W`, 16, register data width
- `ID_W`, 4, register index width
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on `clk` rising edge)
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept; high only in IDLE
- `req_op`  in  2  00 READ2, 01 WRITE, 10 PUSH, 11 POP
- `req_src_a`, `req_src_b`  in  ID_W  operand register indices (READ2)
- `req_dst`  in  ID_W  destination index (WRITE)
- `req_wdata`  in  DATA_W  write data (WRITE)
- `rsp_valid`  out  1  operation complete / operands valid
- `rsp_ready`  in  1  consumer accepts response
- `rsp_op_a`, `rsp_op_b`  out  DATA_W  captured operands
- `rf_rd`, `rf_wn`, `rf_stack_en`, `rf_push_en`, `rf_pop_en`  out  1  register-file strobes
- `rf_reg_id`  out  ID_W  register-file index
- `rf_write_data`  out  DATA_W  register-file write data
- `rf_read_data`  in  DATA_W  register-file read data, valid the cycle after `rf_rd` is sampled

## Operation
- FSM states: IDLE, RD_A, RD_B, CAP_B, WR, STK, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch op, indices and wdata.
  - Go to RD_A (READ2), WR (WRITE) or STK (PUSH/POP).
- RD_A:
  - `rf_rd`=1, `rf_reg_id`=src_a.
  - Go to RD_B.
- RD_B:
  - `rf_rd`=1, `rf_reg_id`=src_b.
  - Capture `rf_read_data` into `rsp_op_a` at the cycle end.
  - Go to CAP_B.
- CAP_B:
  - No strobes.
  - Capture `rf_read_data` into `rsp_op_b`.
  - Go to RESP.
- WR:
  - `rf_wn`=1, `rf_reg_id`=dst, `rf_write_data`=wdata.
  - Go to RESP.
- STK:
  - `rf_stack_en`=1.
  - `rf_push_en`=1 for PUSH, or `rf_pop_en`=1 for POP (never both).
  - `rf_reg_id`=2.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1.
  - Stay until `rsp_ready`, then go to IDLE.
- `rsp_op_a`/`rsp_op_b` change only in RD_B/CAP_B. WRITE, PUSH and POP responses leave them holding their previous values.
- Strobe invariants, every cycle:
  - `rf_rd` and `rf_wn` never both 1.
  - Stack strobes never coincide with `rf_rd` or `rf_wn`.
  - All strobes are 0 outside RD_A/RD_B/WR/STK.
- src_a == src_b still performs two reads; both operands equal that register's value.
- WRITE to register 2 is legal; it is treated as a plain write.
- Stack-pointer wrap is the register file's concern. The sequencer only issues the strobe.
- `rf_reg_id`/`rf_write_data` are 0 when no strobe is active.

## Timing
- Reset (`reset`=0 at a rising edge):
  - State goes to IDLE.
  - `req_ready` is 1 from the first cycle after reset.
  - `rsp_valid`, all `rf_*` strobes, `rf_reg_id`, `rf_write_data`, `rsp_op_a` and `rsp_op_b` are 0.
- Reset mid-operation aborts immediately. No strobe is driven in the cycle after reset is sampled, and any pending response is dropped.
- Latency, with request accepted at edge 0:
  - READ2: strobes in cycles 1–2, `rsp_valid` from cycle 4; 3 strobe/capture cycles.
  - WRITE, PUSH, POP: strobe in cycle 1, `rsp_valid` from cycle 2.
- Throughput: one operation in flight.
  - Next accept is possible at the earliest in the cycle after `rsp_valid && rsp_ready`.
  - So minimum 5 cycles per READ2 and 3 cycles per other ops.
- `rsp_valid` and `rsp_op_*` hold stable while `rsp_ready`=0.
- `req_*` inputs are don't-care except in IDLE with `req_valid`=1.
- All outputs are registered or decoded only from state and latched fields, never from `req_*` inputs combinationally.

## Test plan
- Reset: hold `reset`=0 for 3 cycles in RD_B of a READ2 → next cycle all strobes are 0, `rsp_valid`=0 and `req_ready`=1; no response ever appears for the aborted op.
- Write then read:
  - WRITE dst=5, wdata=16'hBEEF → `rf_wn`=1 with id 5 for exactly one cycle, then `rsp_valid` the next cycle.
  - Then READ2 src_a=5, src_b=0 against a regfile model with r0=16'h0001 → `rsp_op_a`=16'hBEEF, `rsp_op_b`=16'h0001, `rsp_valid` 4 cycles after accept.
- Stack:
  - PUSH → `rf_stack_en`=`rf_push_en`=1 for one cycle with `rf_pop_en`=0.
  - Then POP → symmetric.
  - Model r2 returns to its start value (including 16'hFFFF → 16'h0000 → 16'hFFFF wrap).
- Backpressure: READ2 with `rsp_ready`=0 for 6 cycles → `rsp_valid` and operands stay constant, `req_ready`=0 throughout; accept occurs the cycle after `rsp_ready` is raised.
- Same-register read: READ2 src_a=src_b=7 with r7=16'h1234 → two `rf_rd` cycles, both operands 16'h1234.
- Invariant sweep: 1000 random ops with random `rsp_ready` → the strobe exclusivity assertions never fire, and the register-file model matches a reference array at the end.
